// File: rtl/cell_writer.sv
// Write-side controller for the 4-row Sudoku game RAM: set digit, clear cell or
// load a whole row, done as a read-modify-write that respects per-cell protect bits.
module cell_writer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [1:0]  CmdRow,
  input  logic [1:0]  CmdCol,
  input  logic [3:0]  CmdDigit,
  input  logic [23:0] CmdRowData,
  output logic [1:0]  RamRdAddr,
  input  logic [23:0] RamRdDat,
  output logic [1:0]  RamWrAddr,
  output logic [23:0] RamWrDat,
  output logic        RamWrEn,
  output logic        Done,
  output logic        Rejected,
  output logic [2:0]  DbgState
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MOD  = 3'd2,
    WR   = 3'd3,
    REJ  = 3'd4
  } state_t;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Handshake: a command transfers on a rising edge where CmdValid && CmdReady;
  // CmdReady is registered and high only in IDLE, Cmd* are ignored otherwise.

  state_t      state;
  logic [1:0]  capOp;
  logic [1:0]  capRow;
  logic [1:0]  capCol;
  logic [3:0]  capDigit;
  logic [3:0]  protBits;
  logic        protectHit;
  logic        badDigit;
  logic [23:0] newWord;

  assign DbgState = state;
  assign badDigit = (CmdDigit == 4'd0) || (CmdDigit > 4'd4);

  // Edited row word built from the read data; only the target cell's digit and blank bit move.
  always_comb begin
    newWord    = RamRdDat;
    protBits   = RamRdDat[23:20];
    protectHit = protBits[capCol];
    for (int c = 0; c < 4; c++) begin
      if (capCol == c[1:0]) begin
        if (capOp == OP_CLR) begin
          newWord[4*c +: 4] = 4'd0;
          newWord[16 + c]   = 1'b1;
        end else begin
          newWord[4*c +: 4] = capDigit;
          newWord[16 + c]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      CmdReady  <= 1'b1;
      capOp     <= 2'd0;
      capRow    <= 2'd0;
      capCol    <= 2'd0;
      capDigit  <= 4'd0;
      RamRdAddr <= 2'd0;
      RamWrAddr <= 2'd0;
      RamWrDat  <= 24'd0;
      RamWrEn   <= 1'b0;
      Done      <= 1'b0;
      Rejected  <= 1'b0;
    end else begin
      RamWrEn  <= 1'b0;
      Done     <= 1'b0;
      Rejected <= 1'b0;
      case (state)
        IDLE: begin
          CmdReady <= 1'b1;
          if (CmdValid && CmdReady) begin
            capOp    <= CmdOp;
            capRow   <= CmdRow;
            capCol   <= CmdCol;
            capDigit <= CmdDigit;
            CmdReady <= 1'b0;
            if ((CmdOp == OP_RSVD) || ((CmdOp == OP_SET) && badDigit)) begin
              state    <= REJ;
              Rejected <= 1'b1;
            end else if (CmdOp == OP_LOAD) begin
              // Whole-row load bypasses protection and the read entirely.
              state     <= WR;
              RamWrEn   <= 1'b1;
              Done      <= 1'b1;
              RamWrAddr <= CmdRow;
              RamWrDat  <= CmdRowData;
            end else begin
              state     <= RD;
              RamRdAddr <= CmdRow;
            end
          end
        end
        RD: begin
          state <= MOD;
        end
        MOD: begin
          if (protectHit) begin
            state    <= REJ;
            Rejected <= 1'b1;
          end else begin
            state     <= WR;
            RamWrEn   <= 1'b1;
            Done      <= 1'b1;
            RamWrAddr <= capRow;
            RamWrDat  <= newWord;
          end
        end
        WR, REJ: begin
          state    <= IDLE;
          CmdReady <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          CmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_writer.sv
// Bench for cell_writer: a 4x24 RAM model, a cell-level reference model feeding an
// expected queue, and a monitor that pops on every Done/Rejected pulse.
module tb_cell_writer;

  localparam int W = 27; // {rejected, addr[1:0], data[23:0]}

  logic        CLK;
  logic        RST;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [1:0]  CmdRow;
  logic [1:0]  CmdCol;
  logic [3:0]  CmdDigit;
  logic [23:0] CmdRowData;
  logic [1:0]  RamRdAddr;
  logic [23:0] RamRdDat;
  logic [1:0]  RamWrAddr;
  logic [23:0] RamWrDat;
  logic        RamWrEn;
  logic        Done;
  logic        Rejected;
  logic [2:0]  DbgState;

  logic [23:0] ram [4];
  logic        preEn;
  logic [1:0]  preAddr;
  logic [23:0] preDat;

  logic [23:0] model_mem [4];
  logic [W-1:0] exp_q[$];
  int checks;
  int fails;

  cell_writer dut (
    .CLK(CLK), .RST(RST), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdRow(CmdRow), .CmdCol(CmdCol), .CmdDigit(CmdDigit),
    .CmdRowData(CmdRowData), .RamRdAddr(RamRdAddr), .RamRdDat(RamRdDat),
    .RamWrAddr(RamWrAddr), .RamWrDat(RamWrDat), .RamWrEn(RamWrEn),
    .Done(Done), .Rejected(Rejected), .DbgState(DbgState)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read RAM; a write becomes visible to reads from the next cycle.
  always @(posedge CLK) begin
    if (preEn) ram[preAddr] <= preDat;
    else if (RamWrEn) ram[RamWrAddr] <= RamWrDat;
    RamRdDat <= ram[RamRdAddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cell-level edits on a shadow copy of the RAM.
  task automatic model_cmd(input logic [1:0] op, input logic [1:0] row, input logic [1:0] col,
                           input logic [3:0] digit, input logic [23:0] data,
                           output logic [W-1:0] e);
    logic [23:0] w;
    int sh;
    sh = 4 * int'(col);
    w  = model_mem[row];
    e  = {1'b1, 2'b00, 24'd0};
    if (op == 2'b10) begin
      model_mem[row] = data;
      e = {1'b0, row, data};
    end else if (op == 2'b11) begin
      e = {1'b1, 2'b00, 24'd0};
    end else if ((op == 2'b00) && (digit < 4'd1 || digit > 4'd4)) begin
      e = {1'b1, 2'b00, 24'd0};
    end else if (w[20 + int'(col)]) begin
      e = {1'b1, 2'b00, 24'd0};
    end else begin
      w = w & ~(24'hF << sh);
      if (op == 2'b00) w = (w & ~(24'h1 << (16 + int'(col)))) | ({20'd0, digit} << sh);
      else             w = w | (24'h1 << (16 + int'(col)));
      model_mem[row] = w;
      e = {1'b0, row, w};
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    logic [W-1:0] e;
    if (!RST) begin
      if (Done || Rejected) begin
        check("done_rej_exclusive", 32'(Done && Rejected), 32'd0);
        check("wren_matches_done", 32'(RamWrEn), 32'(Done));
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(Done || Rejected), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rejected", 32'(Rejected), 32'(e[26]));
          if (!e[26]) begin
            check("wr_addr", 32'(RamWrAddr), 32'(e[25:24]));
            check("wr_data", 32'(RamWrDat), 32'(e[23:0]));
          end
        end
      end else if (RamWrEn) begin
        check("stray_wren", 32'(RamWrEn), 32'd0);
      end
    end
  end

  task automatic preload(input logic [1:0] addr, input logic [23:0] dat);
    preEn = 1'b1; preAddr = addr; preDat = dat;
    @(negedge CLK);
    preEn = 1'b0;
    model_mem[addr] = dat;
  endtask

  // Driver: called at a negedge; presents a command and waits for its accept edge.
  // With settle=1 it drops CmdValid and returns the cycles until CmdReady is back.
  task automatic send(input logic [1:0] op, input logic [1:0] row, input logic [1:0] col,
                      input logic [3:0] digit, input logic [23:0] data,
                      input bit settle, output int lat);
    logic [W-1:0] e;
    int n;
    CmdValid = 1'b1; CmdOp = op; CmdRow = row; CmdCol = col;
    CmdDigit = digit; CmdRowData = data;
    n = 0;
    lat = 0;
    while (!CmdReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!CmdReady) begin
      check("accept_timeout", 32'(CmdReady), 32'd1);
      CmdValid = 1'b0;
      return;
    end
    @(posedge CLK);
    model_cmd(op, row, col, digit, data, e);
    exp_q.push_back(e);
    @(negedge CLK);
    lat = 1;
    if (settle) begin
      CmdValid = 1'b0;
      while (!CmdReady && lat < 50) begin
        lat++;
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    int lat;
    CmdValid = 1'b0; CmdOp = 2'd0; CmdRow = 2'd0; CmdCol = 2'd0;
    CmdDigit = 4'd0; CmdRowData = 24'd0;
    preEn = 1'b0; preAddr = 2'd0; preDat = 24'd0;
    checks = 0; fails = 0;
    RST = 1'b0;
    #2 RST = 1'b1;
    #2;
    check("rst_ready", 32'(CmdReady), 32'd1);
    check("rst_rdaddr", 32'(RamRdAddr), 32'd0);
    check("rst_wraddr", 32'(RamWrAddr), 32'd0);
    check("rst_wrdat", 32'(RamWrDat), 32'd0);
    check("rst_wren", 32'(RamWrEn), 32'd0);
    check("rst_done_rej", 32'({Done, Rejected}), 32'd0);
    for (int r = 0; r < 4; r++) preload(2'(r), 24'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Set digit
    preload(2'd2, 24'h0F_0000);
    send(2'b00, 2'd2, 2'd1, 4'd3, 24'd0, 1'b1, lat);
    check("set_latency", lat, 4);
    // Protected cell
    preload(2'd0, 24'h21_4321);
    send(2'b00, 2'd0, 2'd1, 4'd2, 24'd0, 1'b1, lat);
    check("protect_latency", lat, 4);
    // Clear cell
    preload(2'd3, 24'h00_1234);
    send(2'b01, 2'd3, 2'd0, 4'd0, 24'd0, 1'b1, lat);
    check("clear_latency", lat, 4);
    // Load row
    send(2'b10, 2'd1, 2'd0, 4'd0, 24'hF0_2143, 1'b1, lat);
    check("load_latency", lat, 2);
    // Illegal inputs
    send(2'b00, 2'd1, 2'd2, 4'd0, 24'd0, 1'b1, lat);
    check("digit0_latency", lat, 2);
    send(2'b00, 2'd1, 2'd2, 4'd7, 24'd0, 1'b1, lat);
    check("digit7_latency", lat, 2);
    send(2'b11, 2'd1, 2'd2, 4'd2, 24'd0, 1'b1, lat);
    check("rsvd_latency", lat, 2);
    // Boundary digits 1 and 4 on an unprotected cell
    send(2'b00, 2'd1, 2'd3, 4'd1, 24'd0, 1'b1, lat);
    send(2'b00, 2'd1, 2'd0, 4'd4, 24'd0, 1'b1, lat);

    // Reset while in MOD: no write, no pulse, RAM untouched.
    preload(2'd0, 24'h00_0000);
    CmdValid = 1'b1; CmdOp = 2'b00; CmdRow = 2'd0; CmdCol = 2'd2; CmdDigit = 4'd4;
    @(posedge CLK);
    @(negedge CLK);
    CmdValid = 1'b0;
    @(negedge CLK);
    check("mid_state_is_mod", 32'(DbgState), 32'd2);
    RST = 1'b1;
    #1;
    check("mid_rst_wren", 32'(RamWrEn), 32'd0);
    check("mid_rst_pulses", 32'({Done, Rejected}), 32'd0);
    check("mid_rst_ready", 32'(CmdReady), 32'd1);
    check("mid_rst_wrdat", 32'(RamWrDat), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    check("post_rst_ready", 32'(CmdReady), 32'd1);
    check("post_rst_ram", 32'(ram[0]), 32'(model_mem[0]));

    // Random traffic, often back-to-back with CmdValid held high.
    for (int r = 0; r < 4; r++)
      send(2'b10, 2'(r), 2'd0, 4'd0, 24'($urandom), 1'b0, lat);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      logic [3:0] dg;
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      dg = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        CmdValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      send(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), dg,
           ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom) & 24'h0F_FFFF,
           1'($urandom_range(0, 1)), lat);
    end
    CmdValid = 1'b0;
    repeat (8) @(negedge CLK);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < 4; r++) check("final_ram_row", 32'(ram[r]), 32'(model_mem[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cell_writer.md
# cell_writer

Write-side controller for the 4-row Sudoku game RAM. Accepts one edit command at a time from the user-input logic: set a cell digit, clear a cell, or load a whole row. Performs a read-modify-write on the 24-bit row word and honours the per-cell write-protect bits. The game-completion checker reads the same RAM in parallel and observes each write from the cycle after `RamWrEn`.

## Interface

Parameters: none. The word format is fixed:
- `[23:20]` write-protect, one bit per cell.
- `[19:16]` blank flag, one bit per cell.
- `[15:0]` digits, 4 bits per cell. Cell `c` occupies `[4c+3:4c]`, blank bit `16+c`, protect bit `20+c`.

Ports:
- `CLK` in 1 — system clock, all logic on the rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `CmdValid` in 1 — command present.
- `CmdReady` out 1 — block idle; a command is accepted on an edge where `CmdValid && CmdReady`.
- `CmdOp` in 2 — command opcode:
  - `00` set digit.
  - `01` clear cell.
  - `10` load row.
  - `11` reserved.
- `CmdRow` in 2 — target row, i.e. the RAM address.
- `CmdCol` in 2 — target cell within the row.
- `CmdDigit` in 4 — digit for set; legal range is 1..4.
- `CmdRowData` in 24 — full word for load row.
- `RamRdAddr` out 2 — RAM read address.
- `RamRdDat` in 24 — RAM read data, valid the cycle after `RamRdAddr` is stable.
- `RamWrAddr` out 2 — RAM write address.
- `RamWrDat` out 24 — RAM write data.
- `RamWrEn` out 1 — write strobe; the RAM writes on the edge ending a cycle with `RamWrEn=1`.
- `Done` out 1 — one-cycle pulse; the command completed with a write.
- `Rejected` out 1 — one-cycle pulse; the command was dropped with no write.

## Operation

- States are `IDLE`, `RD`, `MOD`, `WR`, `REJ`. `CmdReady=1` only in `IDLE`.
- On accept, all `Cmd*` inputs are captured into registers. Inputs are ignored at every other time.
- Transitions from `IDLE` on accept:
  - Op `11` → `REJ`.
  - Op `00` with `CmdDigit` outside 1..4 (0 or 5..15) → `REJ`, no RAM read.
  - Op `10` → `WR`, with `RamWrDat` = captured `CmdRowData` written verbatim (protect bits included), `RamWrAddr` = row.
  - Op `00` (legal digit) or op `01` → `RD`, with `RamRdAddr` = row.
- `RD` → `MOD`; `RamRdAddr` is held.
- `MOD` registers `RamRdDat` and examines protect bit `20+col`:
  - Protect bit = 1 → `REJ`.
  - Otherwise build the new word and go to `WR`:
    - Set: digit field = `CmdDigit`, blank bit = 0.
    - Clear: digit field = 0, blank bit = 1.
    - All other bits are unchanged.
- `WR`: `RamWrEn=1` and `Done=1` for exactly this cycle, then → `IDLE`.
- `REJ`: `Rejected=1` for exactly this cycle, no write, then → `IDLE`.
- `Done` and `Rejected` are never high together. `RamWrEn` is high only in `WR`.

## Timing

Reset values (applied asynchronously while `RST=1`):
- State `IDLE`, `CmdReady=1`.
- `RamRdAddr=0`, `RamWrAddr=0`, `RamWrDat=0`.
- `RamWrEn=0`, `Done=0`, `Rejected=0`.

Latency, with the accept edge called E0:
- Set and clear: `RD` in E0–E1, `MOD` in E1–E2, `WR`/`REJ` in E2–E3. `CmdReady` is high again after E3, so these take 4 cycles each.
- Load row, and early rejects (reserved op, illegal digit): `WR`/`REJ` in E0–E1, `CmdReady` high after E1, so these take 2 cycles each.

Boundary conditions:
- Back-to-back commands to the same row: the next read is issued only after the previous write edge, so it sees the updated word. No bypass is needed.
- Reset asserted mid-command (any state): the command is dropped, `RamWrEn` falls immediately, and no partial write occurs. After reset deassertion the block is in `IDLE`.
- `CmdValid` held high across completion: a new command is accepted on the first edge with `CmdReady=1`.
- The checker's free-running reads may coincide with `RamWrEn`. The RAM's dual-port semantics are assumed. The new data is visible to reads from the next cycle.

## Test plan

- Set digit:
  - Stimulus: RAM row 2 = `24'h0F_0000`. Command op `00`, row 2, col 1, digit 3.
  - Response: `RamWrEn` in cycle E2–E3, `RamWrAddr=2`, `RamWrDat=24'h0D_0030`, `Done` pulse, `CmdReady` after 4 cycles.
- Protected cell:
  - Stimulus: row 0 = `24'h21_4321`, set col 1, digit 2.
  - Response: `Rejected` pulse in E2–E3, `RamWrEn` stays 0.
- Clear cell:
  - Stimulus: row 3 = `24'h00_1234`, clear col 0.
  - Response: write of `24'h01_1230`, `Done`.
- Load row:
  - Stimulus: row 1, data `24'hF0_2143`.
  - Response: `RamWrEn`, `Done` in E0–E1, `RamWrDat=24'hF0_2143`, ready after 2 cycles.
- Illegal input:
  - Stimulus: digit 0, then digit 7, then op `11`.
  - Response: each gives `Rejected` in E0–E1 and no RAM read or write.
- Reset mid-command:
  - Stimulus: assert `RST` during `MOD`.
  - Response: `RamWrEn`, `Done`, `Rejected` stay 0. `CmdReady=1` and RAM unchanged after release.
